up_sampler: RTL and testbench
=============================

Name: up_sampler

Overview:
- Downstream neighbour of the Gaussian stage. Drains the Gaussian output FIFO and produces a 2x nearest-neighbour upsampled image.
- Each input pixel is emitted twice horizontally.
- Each input row is emitted twice vertically; the second copy is replayed from an internal line buffer.
- Output is a valid/ready pixel stream with start-of-frame and end-of-line markers, feeding the next pyramid level.

Parameters:
- IN_W, 320, input pixels per row (≥2).
- IN_H, 240, input rows per frame (≥1).
- DW, 8, pixel width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  Gaussian FIFO empty flag.
- fifo_valid  in  1  FIFO read data valid, one cycle after fifo_rd_en.
- fifo_dout  in  DW  FIFO read data.
- fifo_rd_en  out  1  FIFO read request.
- valid_out  out  1  output pixel valid.
- ready_in  in  1  downstream accepts pixel when high with valid_out.
- dout  out  DW  output pixel.
- sof  out  1  high with the first pixel of the output frame.
- eol  out  1  high with the last pixel of each output row (column 2*IN_W-1).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: state=IDLE; fifo_rd_en=0, valid_out=0, dout=0, sof=0, eol=0, busy=0; all counters 0; hold register empty; outstanding-read flag clear. Reset mid-frame abandons the frame; the next frame restarts at row 0, col 0.
- Counters: col 0..IN_W-1, row 0..IN_H-1, phase bit (0/1 = first/second horizontal copy), pass bit (0 = FILL copy, 1 = REPLAY copy).
- States:
  - IDLE: go to FILL when fifo_empty=0.
  - FILL: read from FIFO.
    - fifo_rd_en=1 only if fifo_empty=0, hold register empty and no read outstanding. Never read while empty.
    - On fifo_valid: capture into hold, write to line buffer at col, clear outstanding.
    - fifo_valid with no outstanding read is ignored.
  - REPLAY: issue a line-buffer read at col; data is available 1 cycle later into hold. Reads are pipelined ahead so no bubble is needed while ready_in=1.
  - ROW_END: after the REPLAY pass of the last column: row++. If row==IN_H-1 go to IDLE (frame done); else go to FILL.
- Output: valid_out=1 while hold is full. dout=hold. A transfer happens when valid_out && ready_in.
  - phase 0 transfer → phase=1.
  - phase 1 transfer → phase=0, hold emptied, col++. At col==IN_W-1, wrap col to 0: FILL→REPLAY, or REPLAY→ROW_END.
- sof = valid_out && row==0 && pass==0 && col==0 && phase==0. eol = valid_out && col==IN_W-1 && phase==1.
- Backpressure: valid_out, dout, sof and eol are held stable while ready_in=0. No FIFO read or line-buffer read is issued that would overwrite an occupied hold.
- FIFO empty mid-row: valid_out drops after hold drains. Resume without loss or duplication.
- Output frame: 2*IN_W x 2*IN_H pixels. Minimum latency from fifo_rd_en to valid_out: 2 cycles.

Optional Feature:
- Macro UPSAMPLE_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0], reset 0, incremented in the cycle the final eol of a frame transfers; wraps 0xFFFF→0. Adds output overrun, sticky until rst, set if fifo_valid arrives with no read outstanding.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package up_sampler_pkg: state enum {IDLE, FILL, REPLAY, ROW_END}; localparams COL_W=$clog2(IN_W), ROW_W=$clog2(IN_H).
- One sub-module, up_line_buffer: single-port synchronous RAM, IN_W x DW, 1-cycle registered read, write-enable/address/data ports. Writes occur only in FILL and reads only in REPLAY, so a single port suffices.

Test Plan:
- IN_W=4, IN_H=2, FIFO holds 1,2,3,4,5,6,7,8, ready_in=1 → 32 pixels:
  - rows 1 1 2 2 3 3 4 4 twice, then 5 5 6 6 7 7 8 8 twice;
  - sof on the first pixel only; eol on every 8th pixel.
- Same stimulus, ready_in toggling 1-0-0-1 pseudo-randomly → identical pixel sequence; dout stable across every ready_in=0 cycle.
- fifo_empty asserted for 10 cycles after the 2nd pixel → valid_out low after hold drains, no fifo_rd_en while empty; sequence continues 3 3 … unchanged.
- rst pulsed mid-row 1 → all outputs 0 next cycle; a new frame 9..16 outputs starting at 9 with sof.
- Spurious fifo_valid without a read outstanding → ignored, sequence unaffected. With UPSAMPLE_FRAME_CNT_EN defined, overrun=1.
- UPSAMPLE_FRAME_CNT_EN defined, three back-to-back frames → frame_cnt reads 1, 2, 3 after each final eol.

Source files
------------

// File: rtl/up_sampler_pkg.sv
// up_sampler_pkg: shared types and helpers for the 2x nearest-neighbour up-sampler.
//   state_t : top-level sequencing states.
//   cnt_w() : counter width for a 0..n-1 range, never narrower than one bit.
package up_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPLAY,
        ROW_END
    } state_t;

    // $clog2(1) is 0, which would give a zero-width row counter when IN_H == 1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/up_line_buffer.sv
// up_line_buffer: single-port synchronous RAM holding one input row.
//   clk   : clock
//   we    : write enable (data written at addr)
//   re    : read enable (rdata updated from addr on the next edge, otherwise held)
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data
module up_line_buffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/up_sampler.sv
// up_sampler: drains the Gaussian FIFO and emits a 2x nearest-neighbour upsampled frame.
// Each input pixel is sent twice per row; each row is sent twice, the second copy being
// replayed from an internal line buffer.
//   clk, rst            : clock, synchronous active-high reset
//   fifo_empty/valid/dout, fifo_rd_en : FIFO read side (data one cycle after fifo_rd_en)
//   valid_out, ready_in, dout         : output pixel stream
//   sof, eol            : first pixel of frame, last pixel of each output row
//   busy                : state is not IDLE
// Optional (macro UPSAMPLE_FRAME_CNT_EN): frame_cnt (completed output frames, wraps) and
// overrun (sticky, fifo_valid seen with no read outstanding).
module up_sampler
    import up_sampler_pkg::*;
#(
    parameter int unsigned IN_W = 320,
    parameter int unsigned IN_H = 240,
    parameter int unsigned DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic          fifo_valid,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd_en,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [DW-1:0] dout,
    output logic          sof,
    output logic          eol,
    output logic          busy
`ifdef UPSAMPLE_FRAME_CNT_EN
   ,output logic [15:0]   frame_cnt,
    output logic          overrun
`endif
);

    localparam int unsigned COL_W = cnt_w(IN_W);
    localparam int unsigned ROW_W = cnt_w(IN_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

    state_t           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             phase_q;      // 0/1 = first/second horizontal copy
    logic             pass_q;       // 0 = FILL copy, 1 = REPLAY copy
    logic [DW-1:0]    hold_q;
    logic             hold_full_q;
    logic             fifo_pend_q;  // FIFO read issued, data not yet returned
    logic             lb_avail_q;   // line-buffer read data waiting in the RAM output register

    logic             xfer, pix_done, last_col, fifo_take, lb_rd;
    logic [COL_W-1:0] lb_addr;
    logic [DW-1:0]    lb_rdata;

    always_comb begin
        xfer       = hold_full_q && ready_in;
        pix_done   = xfer && phase_q;
        last_col   = (col_q == COL_LAST);
        fifo_rd_en = (state_q == FILL) && !fifo_empty && !hold_full_q && !fifo_pend_q;
        fifo_take  = fifo_valid && fifo_pend_q;
        // First read of a replay row happens with hold empty; after that the next column is
        // fetched during the phase-0 transfer so it is ready when phase 1 completes.
        lb_rd      = (state_q == REPLAY) && !lb_avail_q &&
                     (!hold_full_q || (xfer && !phase_q && !last_col));
        lb_addr    = ((state_q == REPLAY) && hold_full_q) ? col_q + COL_W'(1) : col_q;
        valid_out  = hold_full_q;
        dout       = hold_q;
        sof        = hold_full_q && (row_q == '0) && !pass_q && (col_q == '0) && !phase_q;
        eol        = hold_full_q && last_col && phase_q;
        busy       = (state_q != IDLE);
    end

    up_line_buffer #(
        .DEPTH (IN_W),
        .DW    (DW),
        .AW    (COL_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (fifo_take),
        .re    (lb_rd),
        .addr  (lb_addr),
        .wdata (fifo_dout),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            phase_q     <= 1'b0;
            pass_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            fifo_pend_q <= 1'b0;
            lb_avail_q  <= 1'b0;
        end else begin
            if (fifo_rd_en) begin
                fifo_pend_q <= 1'b1;
            end else if (fifo_take) begin
                fifo_pend_q <= 1'b0;
            end

            if (fifo_take) begin
                hold_q      <= fifo_dout;
                hold_full_q <= 1'b1;
            end else if (lb_avail_q && (!hold_full_q || pix_done)) begin
                hold_q      <= lb_rdata;
                hold_full_q <= 1'b1;
                lb_avail_q  <= 1'b0;
            end else if (pix_done) begin
                hold_full_q <= 1'b0;
            end

            if (lb_rd) begin
                lb_avail_q <= 1'b1;
            end

            if (xfer) begin
                phase_q <= ~phase_q;
            end

            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= FILL;
                        pass_q  <= 1'b0;
                    end
                end
                FILL, REPLAY: begin
                    if (pix_done) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (state_q == FILL) begin
                                state_q <= REPLAY;
                                pass_q  <= 1'b1;
                            end else begin
                                state_q <= ROW_END;
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                ROW_END: begin
                    pass_q <= 1'b0;
                    if (row_q == ROW_LAST) begin
                        row_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        row_q   <= row_q + ROW_W'(1);
                        state_q <= FILL;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UPSAMPLE_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            // Final eol of the frame: last column of the replay copy of the last row.
            if (pix_done && last_col && (state_q == REPLAY) && (row_q == ROW_LAST)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (fifo_valid && !fifo_pend_q) begin
                overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_up_sampler.sv
// tb_up_sampler: self-checking bench for up_sampler with IN_W=4, IN_H=2.
// A FIFO model feeds pixels; the expected output stream is built from the upsampling rules.
module tb_up_sampler;

    localparam int IN_W  = 4;
    localparam int IN_H  = 2;
    localparam int NPIX  = IN_W * IN_H;
    localparam int FRAME = 4 * NPIX;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       fifo_valid = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       valid_out;
    logic       ready_in = 1'b1;
    logic [7:0] dout;
    logic       sof, eol, busy;
`ifdef UPSAMPLE_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        overrun;
`endif

    up_sampler #(
        .IN_W (IN_W),
        .IN_H (IN_H),
        .DW   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .dout       (dout),
        .sof        (sof),
        .eol        (eol),
        .busy       (busy)
`ifdef UPSAMPLE_FRAME_CNT_EN
       ,.frame_cnt  (frame_cnt),
        .overrun    (overrun)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         stab_err = 0;
    int         rd_empty_err = 0;
    logic [7:0] fq[$];
    logic [9:0] got_q[$];        // {sof, eol, dout} of each accepted pixel
    logic [9:0] exp_q[$];
    bit         force_empty = 1'b0;
    bit         spur_req = 1'b0;
    bit         rnd_ready = 1'b0;
    bit         model_rd;
    bit         hold_prev = 1'b0;
    logic [9:0] prev_out = '0;

    // FIFO model: data returned one cycle after a read; optional spurious valid.
    initial begin
        forever begin
            @(negedge clk);
            model_rd = fifo_rd_en && !rst;
            @(posedge clk);
            #1;
            if (rst) begin
                fifo_valid = 1'b0;
            end else if (model_rd && fq.size() > 0) begin
                fifo_valid = 1'b1;
                fifo_dout  = fq.pop_front();
            end else if (!model_rd && spur_req) begin
                fifo_valid = 1'b1;
                fifo_dout  = 8'hEE;
                spur_req   = 1'b0;
            end else begin
                fifo_valid = 1'b0;
            end
            #1;
            fifo_empty = (fq.size() == 0) || force_empty;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Records accepted pixels and protocol violations for the test tasks to judge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev && (!valid_out || {sof, eol, dout} !== prev_out)) stab_err++;
                if (fifo_rd_en && fifo_empty) rd_empty_err++;
                if (valid_out && ready_in) got_q.push_back({sof, eol, dout});
                hold_prev = valid_out && !ready_in;
                prev_out  = {sof, eol, dout};
            end
        end
    end

    // Push one frame into the FIFO and append its upsampled image to the expectation.
    task automatic load_frame(input bit rnd, input int base);
        logic [7:0] px [NPIX];
        for (int i = 0; i < NPIX; i++) begin
            px[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
            fq.push_back(px[i]);
        end
        for (int r = 0; r < IN_H; r++)
            for (int p = 0; p < 2; p++)
                for (int c = 0; c < IN_W; c++)
                    for (int k = 0; k < 2; k++)
                        exp_q.push_back({1'(r == 0 && p == 0 && c == 0 && k == 0),
                                         1'(c == IN_W - 1 && k == 1), px[r * IN_W + c]});
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        fq.delete();
        force_empty = 1'b0;
        spur_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        stab_err = 0;
        rd_empty_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", valid_out);
        end
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en);
        end
        checks++;
        if (dout !== 8'h00) begin
            failures++; $display("FAIL reset_dout got=%h exp=00", dout);
        end
        checks++;
        if ({sof, eol} !== 2'b00) begin
            failures++; $display("FAIL reset_sof_eol got=%b exp=00", {sof, eol});
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
`ifdef UPSAMPLE_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0 || overrun !== 1'b0) begin
            failures++; $display("FAIL reset_opt got=%h/%b exp=0000/0", frame_cnt, overrun);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        load_frame(1'b0, 1);
        wait_got(FRAME, 2000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL basic_timeout got=%0d exp=%0d", got_q.size(), FRAME);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic_px[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL basic_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        rnd_ready = 1'b1;
        load_frame(1'b1, 0);
        wait_got(FRAME, 4000, ok);
        rnd_ready = 1'b0;
        checks++;
        if (!ok) begin
            failures++; $display("FAIL bp_timeout got=%0d exp=%0d", got_q.size(), FRAME);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL bp_px[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stab_err != 0) begin
            failures++; $display("FAIL bp_stable got=%0d exp=0", stab_err);
        end
    endtask

    task automatic test_fifo_empty();
        bit ok;
        do_reset();
        load_frame(1'b0, 1);
        wait_got(2, 1000, ok);
        @(posedge clk);
        #1;
        force_empty = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL empty_drain got=%b%b exp=01", valid_out, busy);
        end
        @(posedge clk);
        #1;
        force_empty = 1'b0;
        wait_got(FRAME, 2000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL empty_timeout got=%0d exp=%0d", got_q.size(), FRAME);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL empty_px[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (rd_empty_err != 0) begin
            failures++; $display("FAIL empty_rd got=%0d exp=0", rd_empty_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        load_frame(1'b0, 1);
        wait_got(20, 2000, ok);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fq.delete();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_out, fifo_rd_en, sof, eol, busy} !== 5'b0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL midrst_out got=%b/%h exp=00000/00",
                     {valid_out, fifo_rd_en, sof, eol, busy}, dout);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        load_frame(1'b0, 9);
        wait_got(FRAME, 2000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL midrst_timeout got=%0d exp=%0d", got_q.size(), FRAME);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL midrst_px[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_spurious();
        bit ok;
        do_reset();
        load_frame(1'b1, 0);
        wait_got(5, 1000, ok);
        spur_req = 1'b1;
        wait_got(FRAME, 2000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL spur_timeout got=%0d exp=%0d", got_q.size(), FRAME);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL spur_px[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
`ifdef UPSAMPLE_FRAME_CNT_EN
        checks++;
        if (overrun !== 1'b1) begin
            failures++; $display("FAIL spur_overrun got=%b exp=1", overrun);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        for (int f = 0; f < 3; f++) load_frame(1'b1, 0);
        for (int f = 1; f <= 3; f++) begin
            wait_got(f * FRAME, 3000, ok);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL b2b_timeout got=%0d exp=%0d", got_q.size(), f * FRAME);
            end
`ifdef UPSAMPLE_FRAME_CNT_EN
            @(negedge clk);
            checks++;
            if (frame_cnt !== 16'(f)) begin
                failures++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt, f);
            end
`endif
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_px[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_fifo_empty();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
